park_occupancy: RTL and testbench

Downstream consumer of the parking-lot sensor FSM's enter/exit pulses. Keeps a saturating count of cars in the lot against a fixed capacity. Drives registered full/empty/fault status for the gate and display logic. Registers and edge-detects its inputs, so glitchy Mealy pulses or multi-cycle highs count exactly once.

---
 rtl/park_pkg.sv | 24 ++
 rtl/park_pulse_edge.sv | 24 ++
 rtl/park_occupancy.sv | 122 ++++++++++++
 tb/tb_park_occupancy.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/park_pkg.sv
// Shared types and defaults for the parking-lot occupancy counter.
package park_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'b00,
      ST_PARTIAL = 2'b01,
      ST_FULL    = 2'b10,
      ST_FAULT   = 2'b11
   } park_state_t;

   localparam int PARK_CAPACITY = 15;

   // Occupancy state implied by a count, ignoring any latched fault.
   function automatic park_state_t state_for(input int cnt, input int cap);
      if (cnt == 0) begin
         return ST_EMPTY;
      end else if (cnt == cap) begin
         return ST_FULL;
      end else begin
         return ST_PARTIAL;
      end
   endfunction

endpackage

// File: rtl/park_pulse_edge.sv
// Two-flop input register with rising-edge detect; a high of any length yields one event.
module park_pulse_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_x,
   output logic o_ev
);

   logic r_q;
   logic r_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q <= 1'b0;
         r_d <= 1'b0;
      end else begin
         r_q <= i_x;
         r_d <= r_q;
      end
   end

   assign o_ev = r_q & ~r_d;

endmodule

// File: rtl/park_occupancy.sv
// Saturating parking-lot occupancy counter with registered full/empty/sticky-fault status.
// Optional peak-occupancy output enabled by defining PARK_PEAK_TRACK_EN.
module park_occupancy
   import park_pkg::*;
#(
   parameter int CAPACITY = PARK_CAPACITY,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enter,
   input  logic             exit,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             fault
`ifdef PARK_PEAK_TRACK_EN
   ,
   output logic [CNT_W-1:0] peak
`endif
);

   localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

   generate
      if ((2 ** CNT_W) - 1 < CAPACITY) begin : g_bad_width
         $error("park_occupancy: CNT_W too narrow for CAPACITY");
      end
   endgenerate

   logic             w_ent_ev;
   logic             w_ext_ev;
   logic             w_inc;
   logic             w_dec;
   logic             w_viol;
   logic [CNT_W-1:0] w_count_next;

   logic [CNT_W-1:0] r_count;
   logic             r_full;
   logic             r_empty;
   logic             r_fault;
   park_state_t      r_state;

   park_pulse_edge u_enter_edge (
      .clk   (clk),
      .reset (reset),
      .i_x   (enter),
      .o_ev  (w_ent_ev)
   );

   park_pulse_edge u_exit_edge (
      .clk   (clk),
      .reset (reset),
      .i_x   (exit),
      .o_ev  (w_ext_ev)
   );

   // Simultaneous enter and exit cancel: no count change and no violation.
   always_comb begin
      w_inc        = w_ent_ev & ~w_ext_ev & (r_count != CAP_C);
      w_dec        = w_ext_ev & ~w_ent_ev & (r_count != '0);
      w_viol       = (w_ent_ev & ~w_ext_ev & (r_count == CAP_C)) |
                     (w_ext_ev & ~w_ent_ev & (r_count == '0));
      w_count_next = r_count;
      if (w_inc) begin
         w_count_next = r_count + CNT_W'(1);
      end else if (w_dec) begin
         w_count_next = r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_fault <= 1'b0;
         r_state <= ST_EMPTY;
      end else begin
         r_count <= w_count_next;
         r_full  <= (w_count_next == CAP_C);
         r_empty <= (w_count_next == '0);
         if (w_viol) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
         end else if ((r_state == ST_FAULT) && !clr) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
         end else begin
            r_state <= state_for(int'(w_count_next), CAPACITY);
            r_fault <= 1'b0;
         end
      end
   end

   assign count = r_count;
   assign full  = r_full;
   assign empty = r_empty;
   assign fault = r_fault;

`ifdef PARK_PEAK_TRACK_EN
   logic             w_clr_fault;
   logic [CNT_W-1:0] r_peak;

   assign w_clr_fault = (r_state == ST_FAULT) & clr & ~w_viol;

   // A fault clear restarts peak tracking from the occupancy at that edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_peak <= '0;
      end else if (w_clr_fault) begin
         r_peak <= w_count_next;
      end else if (w_count_next > r_peak) begin
         r_peak <= w_count_next;
      end
   end

   assign peak = r_peak;
`endif

endmodule

// File: tb/tb_park_occupancy.sv
// Scoreboard bench for park_occupancy: directed test-plan steps followed by randomized traffic.
module tb_park_occupancy;

   localparam int CAP = 15;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enter = 1'b0;
   logic       exit = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] count;
   logic       full;
   logic       empty;
   logic       fault;
`ifdef PARK_PEAK_TRACK_EN
   logic [3:0] peak;
`endif

   always #5 clk = ~clk;

   park_occupancy #(.CAPACITY(CAP), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .enter (enter),
      .exit  (exit),
      .clr   (clr),
      .count (count),
      .full  (full),
      .empty (empty),
      .fault (fault)
`ifdef PARK_PEAK_TRACK_EN
      ,
      .peak  (peak)
`endif
   );

   typedef struct {
      int cnt;
      bit full;
      bit empty;
      bit fault;
      int peak;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   txn = 0;

   // Reference model: occupancy, sticky fault, peak, and the last two sampled input levels.
   int m_cnt = 0;
   bit m_fault = 0;
   int m_peak = 0;
   bit s1e = 0, s2e = 0, s1x = 0, s2x = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s txn=%0d actual=%0d required=%0d", name, txn, act, req);
      end
   endtask

   // Drive one cycle of inputs and push the outputs expected after the following edge.
   task automatic step(input bit rst_n, input bit e, input bit x, input bit c);
      exp_t ex;
      bit   ev_e, ev_x, viol;
      @(negedge clk);
      reset = rst_n;
      enter = e;
      exit  = x;
      clr   = c;
      if (!rst_n) begin
         m_cnt = 0; m_fault = 0; m_peak = 0;
         s1e = 0; s2e = 0; s1x = 0; s2x = 0;
      end else begin
         ev_e = s1e && !s2e;
         ev_x = s1x && !s2x;
         viol = 0;
         if (ev_e && !ev_x) begin
            if (m_cnt == CAP) viol = 1; else m_cnt = m_cnt + 1;
         end
         if (ev_x && !ev_e) begin
            if (m_cnt == 0) viol = 1; else m_cnt = m_cnt - 1;
         end
         if (viol) begin
            m_fault = 1;
         end else if (m_fault && c) begin
            m_fault = 0;
            m_peak = m_cnt;
         end
         if (m_cnt > m_peak) m_peak = m_cnt;
         s2e = s1e; s1e = e;
         s2x = s1x; s1x = x;
      end
      ex.cnt = m_cnt;
      ex.full = (m_cnt == CAP);
      ex.empty = (m_cnt == 0);
      ex.fault = m_fault;
      ex.peak = m_peak;
      exp_q.push_back(ex);
   endtask

   task automatic pulse(input bit e, input bit x, input int n);
      for (int i = 0; i < n; i++) begin
         step(1, e, x, 0);
         step(1, 0, 0, 0);
      end
   endtask

   // Monitor: every cycle the DUT presents a result; compare it with the oldest expectation.
   initial begin
      exp_t ex;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            txn++;
            $display("txn %0d rst=%0b en=%0b ex=%0b clr=%0b -> count=%0d full=%0b empty=%0b fault=%0b",
                     txn, reset, enter, exit, clr, count, full, empty, fault);
            check("count", int'(count), ex.cnt);
            check("full", int'(full), int'(ex.full));
            check("empty", int'(empty), int'(ex.empty));
            check("fault", int'(fault), int'(ex.fault));
`ifdef PARK_PEAK_TRACK_EN
            check("peak", int'(peak), ex.peak);
`endif
         end
      end
   end

   initial begin
      int pe_tab[8] = '{70, 30, 85, 15, 50, 90, 10, 50};
      int pe;
      bit r, e, x, c;

      // Reset held, then idle.
      repeat (3) step(0, 0, 0, 0);
      repeat (2) step(1, 0, 0, 0);
      // Long enter high counts once, then single pulses.
      repeat (5) step(1, 1, 0, 0);
      repeat (2) step(1, 0, 0, 0);
      pulse(1, 0, 3);
      // Fill to capacity, overflow, clear.
      pulse(1, 0, 11);
      pulse(1, 0, 1);
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      // Underflow from empty, then enter keeps fault.
      step(0, 0, 0, 0);
      pulse(0, 1, 1);
      pulse(1, 0, 1);
      // Simultaneous enter/exit at 0, 7 and 15.
      step(0, 0, 0, 0);
      pulse(1, 1, 1);
      pulse(1, 0, 7);
      pulse(1, 1, 1);
      pulse(1, 0, 8);
      pulse(1, 1, 1);
      // Reset mid-burst at 9 with enter high.
      step(0, 0, 0, 0);
      pulse(1, 0, 9);
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      // Peak 0->6->2, then fault and clear.
      step(0, 0, 0, 0);
      pulse(1, 0, 6);
      pulse(0, 1, 4);
      pulse(0, 1, 3);
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);

      // Randomized traffic in phases of differing enter bias.
      for (int ph = 0; ph < 8; ph++) begin
         pe = pe_tab[ph];
         for (int i = 0; i < 60; i++) begin
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 99) < pe);
            x = ($urandom_range(0, 99) < (100 - pe));
            c = ($urandom_range(0, 19) == 0);
            step(r, e, x, c);
         end
      end

      step(1, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
